// File: rtl/lcd_text_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_text_ctrl
// Character-LCD controller for HD44780-compatible modules. Application logic
// writes characters to any (row, col) through a valid/ready port. The
// controller handles power-up delay, the init command sequence, cursor
// addressing and all enable/wait timing, in either 8-bit or 4-bit bus mode.
//
// Ports
//   clk_lcd    : sole clock, rising edge
//   rst        : synchronous active-high reset
//   wr_valid   : host write request
//   wr_ready   : controller can accept a write (high only in IDLE)
//   wr_row     : target row
//   wr_col     : target column
//   wr_char    : character code
//   init_done  : initialisation finished; stays high until reset
//   LCD_EN     : registered LCD enable; the LCD latches on its falling edge
//   RS         : 0 = command, 1 = data
//   RW         : always 0 (write only)
//   DB8        : LCD data bus (4-bit mode uses DB8[7:4], DB8[3:0] held at 0)
// ---------------------------------------------------------------------------
module lcd_text_ctrl #(
    parameter int COLS      = 16,
    parameter int ROWS      = 2,
    parameter int BUS4      = 0,
    parameter int EN_CYCLES = 4,
    parameter int CMD_WAIT  = 50,
    parameter int CLR_WAIT  = 2000,
    parameter int PWR_WAIT  = 15000
) (
    input  logic       clk_lcd,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_row,
    input  logic [5:0] wr_col,
    input  logic [7:0] wr_char,
    output logic       init_done,
    output logic       LCD_EN,
    output logic       RS,
    output logic       RW,
    output logic [7:0] DB8
);

    // One shared counter serves the power-up delay, enable width and waits,
    // so it is sized for the longest of them.
    localparam int M1   = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int M2   = (M1 > CMD_WAIT) ? M1 : CMD_WAIT;
    localparam int MAXC = (M2 > EN_CYCLES) ? M2 : EN_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    // Function set: 0x20 | DL(8-bit)<<4 | N(2 lines)<<3
    localparam logic [7:0] FSET = 8'h20 | ((BUS4 == 0) ? 8'h10 : 8'h00)
                                        | ((ROWS == 2) ? 8'h08 : 8'h00);
    localparam logic [2:0] INIT_LAST = (BUS4 != 0) ? 3'd4 : 3'd3;

    typedef enum logic [2:0] {T_PWR, T_INIT, T_IDLE, T_ADDR, T_DATA} top_e;
    typedef enum logic [2:0] {B_NONE, B_SETUP, B_EN_HI, B_NIB_GAP, B_WAIT} byte_e;

    top_e          top_q, top_d;
    byte_e         sub_q, sub_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    byte_q, byte_d;
    logic          rs_q, rs_d;
    logic          nib_q, nib_d;
    logic          single_q, single_d;
    logic          en_q, en_d;
    logic [7:0]    db_q, db_d;
    logic          done_q, done_d;
    logic          row_q, row_d;
    logic [5:0]    col_q, col_d;
    logic [7:0]    char_q, char_d;
    logic          curRow_q, curRow_d;
    logic [5:0]    curCol_q, curCol_d;
    logic          curVld_q, curVld_d;

    logic [2:0]    tblIdx, tblK;
    logic [7:0]    tblByte;
    logic          tblSingle;
    logic [CW-1:0] waitLast;
    logic          byteDone;
    logic          outOfRange;
    logic          cursorHit;
    logic          start;
    logic [7:0]    stByte;
    logic          stRs;
    logic          stSingle;

    // Init command table. The entry fetched is the one about to be sent:
    // entry 0 when leaving PWR, otherwise the entry after the current one.
    // In 4-bit mode the table starts with the lone 0x2 nibble that switches
    // the module into 4-bit interface mode.
    always_comb begin
        tblIdx    = (top_q == T_PWR) ? 3'd0 : idx_q + 3'd1;
        tblK      = (BUS4 != 0) ? tblIdx : tblIdx + 3'd1;
        tblSingle = (tblK == 3'd0);
        case (tblK)
            3'd0:    tblByte = 8'h20;
            3'd1:    tblByte = FSET;
            3'd2:    tblByte = 8'h0C;
            3'd3:    tblByte = 8'h06;
            default: tblByte = 8'h01;
        endcase
    end

    // Clear display needs the long wait; everything else uses the short one.
    always_comb begin
        waitLast   = (!rs_q && byte_q == 8'h01) ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);
        byteDone   = (sub_q == B_WAIT) && (cnt_q == waitLast);
        outOfRange = (col_q >= 6'(COLS)) || ((ROWS == 1) && row_q);
        cursorHit  = curVld_q && (curRow_q == row_q) && (curCol_q == col_q);
    end

    // Next-state logic. The byte sender advances on its own; the top FSM
    // only reacts to byteDone and, when it has another byte to send, raises
    // 'start' so the next SETUP follows the finished WAIT with no idle cycle.
    always_comb begin
        top_d    = top_q;
        sub_d    = sub_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        byte_d   = byte_q;
        rs_d     = rs_q;
        nib_d    = nib_q;
        single_d = single_q;
        done_d   = done_q;
        row_d    = row_q;
        col_d    = col_q;
        char_d   = char_q;
        curRow_d = curRow_q;
        curCol_d = curCol_q;
        curVld_d = curVld_q;
        start    = 1'b0;
        stByte   = 8'h00;
        stRs     = 1'b0;
        stSingle = 1'b0;

        case (sub_q)
            B_SETUP: begin
                sub_d = B_EN_HI;
                cnt_d = '0;
            end
            B_EN_HI: begin
                if (cnt_q == CW'(EN_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (BUS4 != 0 && !nib_q && !single_q) begin
                        sub_d = B_NIB_GAP;
                    end else begin
                        sub_d = B_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            B_NIB_GAP: begin
                sub_d = B_EN_HI;
                nib_d = 1'b1;
                cnt_d = '0;
            end
            B_WAIT: begin
                if (byteDone) begin
                    sub_d = B_NONE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase

        case (top_q)
            T_PWR: begin
                if (cnt_q == CW'(PWR_WAIT - 1)) begin
                    top_d    = T_INIT;
                    idx_d    = 3'd0;
                    start    = 1'b1;
                    stByte   = tblByte;
                    stSingle = tblSingle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            T_INIT: begin
                if (byteDone) begin
                    if (idx_q == INIT_LAST) begin
                        top_d  = T_IDLE;
                        done_d = 1'b1;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        start    = 1'b1;
                        stByte   = tblByte;
                        stSingle = tblSingle;
                    end
                end
            end
            T_IDLE: begin
                if (wr_valid) begin
                    row_d  = wr_row;
                    col_d  = wr_col;
                    char_d = wr_char;
                    top_d  = T_ADDR;
                end
            end
            T_ADDR: begin
                // First ADDR cycle is the decision cycle: drop, skip the
                // address command on a cursor hit, or send Set DDRAM Address.
                if (sub_q == B_NONE) begin
                    if (outOfRange) begin
                        top_d = T_IDLE;
                    end else if (cursorHit) begin
                        top_d  = T_DATA;
                        start  = 1'b1;
                        stByte = char_q;
                        stRs   = 1'b1;
                    end else begin
                        start  = 1'b1;
                        stByte = {1'b1, row_q, col_q};
                    end
                end else if (byteDone) begin
                    top_d  = T_DATA;
                    start  = 1'b1;
                    stByte = char_q;
                    stRs   = 1'b1;
                end
            end
            T_DATA: begin
                // Past the last visible column the LCD would write into
                // hidden DDRAM, so the cursor is invalidated there.
                if (byteDone) begin
                    top_d    = T_IDLE;
                    curRow_d = row_q;
                    curCol_d = col_q + 6'd1;
                    curVld_d = (col_q + 6'd1) != 6'(COLS);
                end
            end
            default: top_d = T_PWR;
        endcase

        if (start) begin
            sub_d    = B_SETUP;
            cnt_d    = '0;
            byte_d   = stByte;
            rs_d     = stRs;
            single_d = stSingle;
            nib_d    = 1'b0;
        end
    end

    // Pin values are computed from the next state so LCD_EN and DB8 come
    // straight out of flops and line up with the byte-sender state.
    always_comb begin
        en_d = (sub_d == B_EN_HI);
        if (BUS4 != 0) begin
            db_d = nib_d ? {byte_d[3:0], 4'h0} : {byte_d[7:4], 4'h0};
        end else begin
            db_d = byte_d;
        end
    end

    // State register; reset aborts any transfer and restarts power-up.
    always_ff @(posedge clk_lcd) begin
        if (rst) begin
            top_q    <= T_PWR;
            sub_q    <= B_NONE;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            byte_q   <= 8'h00;
            rs_q     <= 1'b0;
            nib_q    <= 1'b0;
            single_q <= 1'b0;
            en_q     <= 1'b0;
            db_q     <= 8'h00;
            done_q   <= 1'b0;
            row_q    <= 1'b0;
            col_q    <= 6'd0;
            char_q   <= 8'h00;
            curRow_q <= 1'b0;
            curCol_q <= 6'd0;
            curVld_q <= 1'b0;
        end else begin
            top_q    <= top_d;
            sub_q    <= sub_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            rs_q     <= rs_d;
            nib_q    <= nib_d;
            single_q <= single_d;
            en_q     <= en_d;
            db_q     <= db_d;
            done_q   <= done_d;
            row_q    <= row_d;
            col_q    <= col_d;
            char_q   <= char_d;
            curRow_q <= curRow_d;
            curCol_q <= curCol_d;
            curVld_q <= curVld_d;
        end
    end

    assign wr_ready  = (top_q == T_IDLE);
    assign init_done = done_q;
    assign LCD_EN    = en_q;
    assign RS        = rs_q;
    assign RW        = 1'b0;
    assign DB8       = db_q;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_text_ctrl
// Three controller instances share the clock and write inputs; the ones not
// under test are held in reset. Instance 0: 8-bit, 2 rows. Instance 1:
// 8-bit, 1 row. Instance 2: 4-bit, 2 rows. A negedge monitor records every
// LCD_EN pulse ({RS, DB8} at the pulse and its width) for the selected one.
// ---------------------------------------------------------------------------
module tb_lcd_text_ctrl;

    logic       clk = 1'b0;
    logic       rstv [3];
    logic       wrValid;
    logic       wrRow;
    logic [5:0] wrCol;
    logic [7:0] wrChar;
    logic       en [3];
    logic       rsO [3];
    logic       rwO [3];
    logic       rdy [3];
    logic       done [3];
    logic [7:0] db [3];

    int         sel;
    logic       mEn, mRs, mRw, mRdy, mDone;
    logic [7:0] mDb;

    int         checks = 0;
    int         failures = 0;
    logic [8:0] pulseQ [$];
    int         widthQ [$];
    logic       prevEn = 1'b0;
    int         curW = 0;
    int         rdyViol = 0;
    int         nibViol = 0;

    typedef struct {
        int         dut;
        logic       row;
        logic [5:0] col;
        logic [7:0] ch;
        int         gap;
        int         np;
        logic [8:0] exp [4];
    } vec_t;

    vec_t       vecs [11];
    logic [8:0] expInit8 [4];
    logic [8:0] expInit4 [9];

    always #5 clk = ~clk;

    lcd_text_ctrl #(.COLS(16), .ROWS(2), .BUS4(0), .EN_CYCLES(2), .CMD_WAIT(3),
                    .CLR_WAIT(10), .PWR_WAIT(5)) dut0 (
        .clk_lcd(clk), .rst(rstv[0]), .wr_valid(wrValid), .wr_ready(rdy[0]),
        .wr_row(wrRow), .wr_col(wrCol), .wr_char(wrChar), .init_done(done[0]),
        .LCD_EN(en[0]), .RS(rsO[0]), .RW(rwO[0]), .DB8(db[0]));

    lcd_text_ctrl #(.COLS(16), .ROWS(1), .BUS4(0), .EN_CYCLES(2), .CMD_WAIT(3),
                    .CLR_WAIT(10), .PWR_WAIT(5)) dut1 (
        .clk_lcd(clk), .rst(rstv[1]), .wr_valid(wrValid), .wr_ready(rdy[1]),
        .wr_row(wrRow), .wr_col(wrCol), .wr_char(wrChar), .init_done(done[1]),
        .LCD_EN(en[1]), .RS(rsO[1]), .RW(rwO[1]), .DB8(db[1]));

    lcd_text_ctrl #(.COLS(16), .ROWS(2), .BUS4(1), .EN_CYCLES(2), .CMD_WAIT(3),
                    .CLR_WAIT(10), .PWR_WAIT(5)) dut2 (
        .clk_lcd(clk), .rst(rstv[2]), .wr_valid(wrValid), .wr_ready(rdy[2]),
        .wr_row(wrRow), .wr_col(wrCol), .wr_char(wrChar), .init_done(done[2]),
        .LCD_EN(en[2]), .RS(rsO[2]), .RW(rwO[2]), .DB8(db[2]));

    // Route the selected instance's pins to the monitor/checker signals.
    always_comb begin
        mEn   = en[sel];
        mRs   = rsO[sel];
        mRw   = rwO[sel];
        mRdy  = rdy[sel];
        mDone = done[sel];
        mDb   = db[sel];
    end

    // Pulse recorder, away from the active edge.
    always @(negedge clk) begin
        if (mEn) begin
            if (!prevEn) begin
                pulseQ.push_back({mRs, mDb});
                curW = 1;
            end else begin
                curW = curW + 1;
            end
        end else if (prevEn) begin
            widthQ.push_back(curW);
        end
        if (mEn && mRdy) rdyViol = rdyViol + 1;
        if (sel == 2 && mDb[3:0] != 4'h0) nibViol = nibViol + 1;
        prevEn = mEn;
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic checkPulse(input string nm, input int i, input logic [8:0] e);
        logic [8:0] got;
        got = (i < pulseQ.size()) ? pulseQ[i] : 9'h1FF;
        checkOutput($sformatf("%s_pulse%0d", nm, i), {23'd0, got}, {23'd0, e});
    endtask

    task automatic checkWidth(input string nm, input int i);
        int got;
        got = (i < widthQ.size()) ? widthQ[i] : -1;
        checkOutput($sformatf("%s_width%0d", nm, i), got, 2);
    endtask

    // Reset instance d, check its pins during reset, release, and measure
    // edges until init_done (first edge with rst low counts as 1).
    task automatic initDut(input int d, input int expLat, input string nm);
        int lat;
        sel = d;
        rstv[d] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput({nm, "_rst_pins"}, {19'd0, mEn, mRs, mRw, mDb, mRdy, mDone}, 32'd0);
        pulseQ.delete();
        widthQ.delete();
        rstv[d] = 1'b0;
        lat = 0;
        while (!mDone && lat < 300) begin
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        checkOutput({nm, "_init_latency"}, lat, expLat);
    endtask

    // One host write: wait for ready, present for one edge, then count edges
    // until ready returns and compare the recorded bus pulses.
    task automatic applyStimulus(input int i);
        int n;
        int gap;
        string nm;
        nm = $sformatf("v%0d", i);
        n = 0;
        while (!mRdy && n < 300) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        checkOutput({nm, "_ready_before"}, {31'd0, mRdy}, 32'd1);
        pulseQ.delete();
        widthQ.delete();
        wrRow   = vecs[i].row;
        wrCol   = vecs[i].col;
        wrChar  = vecs[i].ch;
        wrValid = 1'b1;
        @(posedge clk);
        #1;
        wrValid = 1'b0;
        gap = 0;
        while (!mRdy && gap < 300) begin
            @(posedge clk);
            #1;
            gap = gap + 1;
        end
        checkOutput({nm, "_ready_gap"}, gap, vecs[i].gap);
        checkOutput({nm, "_pulse_count"}, pulseQ.size(), vecs[i].np);
        for (int k = 0; k < vecs[i].np; k++) checkPulse(nm, k, vecs[i].exp[k]);
    endtask

    function automatic vec_t mkVec(input int d, input logic r, input logic [5:0] c,
                                   input logic [7:0] ch, input int g, input int np,
                                   input logic [8:0] e0, input logic [8:0] e1,
                                   input logic [8:0] e2, input logic [8:0] e3);
        vec_t v;
        v.dut = d; v.row = r; v.col = c; v.ch = ch; v.gap = g; v.np = np;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    // Sends the outputs of checkChecker-free checks and runs the whole test.
    initial begin
        int n;
        rstv[0] = 1'b1; rstv[1] = 1'b1; rstv[2] = 1'b1;
        wrValid = 1'b0; wrRow = 1'b0; wrCol = 6'd0; wrChar = 8'h00;
        sel = 0;

        // Byte cost 8-bit = 1+2+3 = 6, so hit = 7 and re-address = 13.
        // Byte cost 4-bit = 1+2+2+1+3 = 9, so re-address = 19.
        vecs[0]  = mkVec(0, 1'b0, 6'd0,  8'h41, 13, 2, 9'h080, 9'h141, 9'h000, 9'h000);
        vecs[1]  = mkVec(0, 1'b0, 6'd1,  8'h42,  7, 1, 9'h142, 9'h000, 9'h000, 9'h000);
        vecs[2]  = mkVec(0, 1'b0, 6'd15, 8'h58, 13, 2, 9'h08F, 9'h158, 9'h000, 9'h000);
        vecs[3]  = mkVec(0, 1'b0, 6'd15, 8'h59, 13, 2, 9'h08F, 9'h159, 9'h000, 9'h000);
        vecs[4]  = mkVec(0, 1'b1, 6'd0,  8'h5A, 13, 2, 9'h0C0, 9'h15A, 9'h000, 9'h000);
        vecs[5]  = mkVec(0, 1'b0, 6'd16, 8'h51,  1, 0, 9'h000, 9'h000, 9'h000, 9'h000);
        vecs[6]  = mkVec(0, 1'b1, 6'd1,  8'h62,  7, 1, 9'h162, 9'h000, 9'h000, 9'h000);
        vecs[7]  = mkVec(0, 1'b1, 6'd39, 8'h71,  1, 0, 9'h000, 9'h000, 9'h000, 9'h000);
        vecs[8]  = mkVec(1, 1'b1, 6'd3,  8'h51,  1, 0, 9'h000, 9'h000, 9'h000, 9'h000);
        vecs[9]  = mkVec(1, 1'b0, 6'd3,  8'h52, 13, 2, 9'h083, 9'h152, 9'h000, 9'h000);
        vecs[10] = mkVec(2, 1'b0, 6'd0,  8'h41, 19, 4, 9'h080, 9'h000, 9'h140, 9'h110);

        expInit8 = '{9'h038, 9'h00C, 9'h006, 9'h001};
        expInit4 = '{9'h020, 9'h020, 9'h080, 9'h000, 9'h0C0,
                     9'h000, 9'h060, 9'h000, 9'h010};

        // 8-bit, 2 rows: 5 + 3*6 + 13 = 36.
        initDut(0, 36, "a_init");
        checkOutput("a_init_count", pulseQ.size(), 4);
        for (int k = 0; k < 4; k++) begin
            checkPulse("a_init", k, expInit8[k]);
            checkWidth("a_init", k);
        end
        for (int i = 0; i < 11; i++) if (vecs[i].dut == 0) applyStimulus(i);

        // Reset during the data byte's enable-high phase.
        n = 0;
        while (!mRdy && n < 300) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        wrRow = 1'b0; wrCol = 6'd5; wrChar = 8'h4D; wrValid = 1'b1;
        @(posedge clk);
        #1;
        wrValid = 1'b0;
        n = 0;
        while (!(mEn && mRs) && n < 100) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        checkOutput("midrst_reached_data_en", {30'd0, mEn, mRs}, 32'd3);
        rstv[0] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_pins", {29'd0, mEn, mRdy, mDone}, 32'd0);
        initDut(0, 36, "a_reinit");
        checkOutput("a_reinit_count", pulseQ.size(), 4);
        for (int k = 0; k < 4; k++) checkPulse("a_reinit", k, expInit8[k]);
        rstv[0] = 1'b1;

        // 8-bit, 1 row: function set drops N.
        initDut(1, 36, "b_init");
        checkOutput("b_init_count", pulseQ.size(), 4);
        checkPulse("b_init", 0, 9'h030);
        for (int i = 0; i < 11; i++) if (vecs[i].dut == 1) applyStimulus(i);
        rstv[1] = 1'b1;

        // 4-bit, 2 rows: 5 + 6 + 3*9 + 16 = 54.
        initDut(2, 54, "c_init");
        checkOutput("c_init_count", pulseQ.size(), 9);
        for (int k = 0; k < 9; k++) begin
            checkPulse("c_init", k, expInit4[k]);
            checkWidth("c_init", k);
        end
        for (int i = 0; i < 11; i++) if (vecs[i].dut == 2) applyStimulus(i);
        rstv[2] = 1'b1;

        checkOutput("ready_during_en", rdyViol, 0);
        checkOutput("nibble_low_bits", nibViol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
